// File: rtl/conv_pkg.sv
// Shared definitions for the convolution address sequencer: FSM states,
// default address widths and the stride field width.
package conv_pkg;

  localparam int AW_DEF = 10;
  localparam int KW_DEF = 6;
  localparam int SW     = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A stride of zero would never advance the window, so it runs as a stride of one.
  function automatic logic [SW-1:0] eff_stride(input logic [SW-1:0] s);
    return (s == 2'd0) ? 2'd1 : s;
  endfunction

endpackage

// File: rtl/conv_addr_sequencer.sv
// Address/control sequencer for a 1-D convolution: walks every valid window
// of an N-sample input with a K-tap kernel at stride S, one tap per cycle.
module conv_addr_sequencer
  import conv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int KW = KW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] in_len,
  input  logic [KW-1:0] kr_len,
  input  logic [SW-1:0] stride,
  output logic [AW-1:0] in_addr,
  output logic [KW-1:0] kr_addr,
  output logic          mac_en,
  output logic          acc_clr,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Window-fit arithmetic is carried two bits wider so base+S+K can never wrap.
  localparam int EW = ((AW > KW) ? AW : KW) + 2;

  state_e        state_r;
  logic [AW-1:0] n_r, base_r, j_r, in_addr_r, out_addr_r;
  logic [KW-1:0] k_r, tap_r, kr_addr_r;
  logic [SW-1:0] s_r;
  logic          mac_en_r, acc_clr_r, out_we_r, busy_r, done_r, err_r;

  logic          cfg_ok_s, last_tap_s, fits_s;
  logic [KW-1:0] tap_nx_s;
  logic [AW-1:0] base_nx_s;

  assign cfg_ok_s   = (in_len != '0) && (kr_len != '0) && (EW'(kr_len) <= EW'(in_len));
  assign tap_nx_s   = tap_r + KW'(1);
  assign last_tap_s = (tap_nx_s == k_r);
  assign base_nx_s  = base_r + AW'(s_r);
  assign fits_s     = (EW'(base_r) + EW'(s_r) + EW'(k_r)) <= EW'(n_r);

  // Sequencer FSM; every output is a flop loaded alongside the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      n_r        <= '0;
      k_r        <= '0;
      s_r        <= '0;
      base_r     <= '0;
      tap_r      <= '0;
      j_r        <= '0;
      in_addr_r  <= '0;
      kr_addr_r  <= '0;
      out_addr_r <= '0;
      mac_en_r   <= 1'b0;
      acc_clr_r  <= 1'b0;
      out_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      mac_en_r  <= 1'b0;
      acc_clr_r <= 1'b0;
      out_we_r  <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          in_addr_r  <= '0;
          kr_addr_r  <= '0;
          out_addr_r <= '0;
          busy_r     <= 1'b0;
          if (start && cfg_ok_s) begin
            n_r       <= in_len;
            k_r       <= kr_len;
            s_r       <= eff_stride(stride);
            base_r    <= '0;
            tap_r     <= '0;
            j_r       <= '0;
            state_r   <= ST_SETUP;
            acc_clr_r <= 1'b1;
            busy_r    <= 1'b1;
          end else if (start) begin
            err_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (abort) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_addr_r  <= '0;
            kr_addr_r  <= '0;
            out_addr_r <= '0;
          end else begin
            state_r   <= ST_MAC;
            tap_r     <= '0;
            in_addr_r <= base_r;
            kr_addr_r <= '0;
            mac_en_r  <= 1'b1;
          end
        end
        ST_MAC: begin
          if (abort) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_addr_r  <= '0;
            kr_addr_r  <= '0;
            out_addr_r <= '0;
          end else if (last_tap_s) begin
            state_r    <= ST_WRITE;
            out_we_r   <= 1'b1;
            out_addr_r <= j_r;
            acc_clr_r  <= 1'b1;
          end else begin
            tap_r     <= tap_nx_s;
            in_addr_r <= base_r + AW'(tap_nx_s);
            kr_addr_r <= tap_nx_s;
            mac_en_r  <= 1'b1;
          end
        end
        ST_WRITE: begin
          // The write strobe already went out this cycle; abort only cancels what follows.
          if (abort) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_addr_r  <= '0;
            kr_addr_r  <= '0;
            out_addr_r <= '0;
          end else if (fits_s) begin
            base_r    <= base_nx_s;
            j_r       <= j_r + AW'(1);
            tap_r     <= '0;
            state_r   <= ST_MAC;
            in_addr_r <= base_nx_s;
            kr_addr_r <= '0;
            mac_en_r  <= 1'b1;
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          in_addr_r  <= '0;
          kr_addr_r  <= '0;
          out_addr_r <= '0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          in_addr_r  <= '0;
          kr_addr_r  <= '0;
          out_addr_r <= '0;
        end
      endcase
    end
  end

  assign in_addr  = in_addr_r;
  assign kr_addr  = kr_addr_r;
  assign out_addr = out_addr_r;
  assign mac_en   = mac_en_r;
  assign acc_clr  = acc_clr_r;
  assign out_we   = out_we_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule
